axi_lite_xbar: RTL and testbench

AXI_LITE_XBAR -- requirements
Module: axi_lite_xbar

---
 rtl/axi_lite_xbar_if.sv | 30 +++
 rtl/axi_lite_xbar.sv | 190 +++++++++++++++++++
 tb/tb_axi_lite_xbar.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_xbar_if.sv
// AXI-Lite channel bundle shared by the crossbar, its upstream master and its slaves.
// Carries the five valid/ready channels with 32-bit address/data and a 4-bit byte mask.
interface axi_lite_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_xbar.sv
// One-master, three-slave AXI-Lite crossbar (SRAM, UART, CLINT) with independent read and
// write FSMs, zero-latency combinational routing and an internal error responder.
module axi_lite_xbar (
    input logic       clk,
    input logic       reset,
    axi_lite_if.slave  m,
    axi_lite_if.master sram,
    axi_lite_if.master uart,
    axi_lite_if.master clint
);
    localparam logic [1:0] SEL_SRAM  = 2'd0;
    localparam logic [1:0] SEL_UART  = 2'd1;
    localparam logic [1:0] SEL_CLINT = 2'd2;
    localparam logic [1:0] SEL_ERR   = 2'd3;

    typedef enum logic [1:0] {RD_IDLE, RD_BUSY, RD_ERR} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_BUSY, WR_ERR_W, WR_ERR_B} wr_state_t;

    // UART and CLINT windows are each one 8-byte aligned block, so compare above bit 3.
    function automatic logic [1:0] decode(input logic [31:0] addr);
        if (addr[31:27] == 5'b10000)        return SEL_SRAM;
        if (addr[31:3] == 29'h1400_007F)    return SEL_UART;
        if (addr[31:3] == 29'h1400_0009)    return SEL_CLINT;
        return SEL_ERR;
    endfunction

    rd_state_t  rd_state, rd_next;
    wr_state_t  wr_state, wr_next;
    logic [1:0] rd_sel, wr_sel;
    logic [1:0] rd_dec, wr_dec;

    logic [2:0]  s_arvalid, s_arready, s_rvalid, s_rready;
    logic [2:0]  s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_rdata [3];
    logic [1:0]  s_rresp [3];
    logic [1:0]  s_bresp [3];

    assign rd_dec = decode(m.araddr);
    assign wr_dec = decode(m.awaddr);

    assign s_arready = {clint.arready, uart.arready, sram.arready};
    assign s_rvalid  = {clint.rvalid,  uart.rvalid,  sram.rvalid};
    assign s_awready = {clint.awready, uart.awready, sram.awready};
    assign s_wready  = {clint.wready,  uart.wready,  sram.wready};
    assign s_bvalid  = {clint.bvalid,  uart.bvalid,  sram.bvalid};
    assign s_rdata = '{sram.rdata, uart.rdata, clint.rdata};
    assign s_rresp = '{sram.rresp, uart.rresp, clint.rresp};
    assign s_bresp = '{sram.bresp, uart.bresp, clint.bresp};

    assign {clint.arvalid, uart.arvalid, sram.arvalid} = s_arvalid;
    assign {clint.rready,  uart.rready,  sram.rready}  = s_rready;
    assign {clint.awvalid, uart.awvalid, sram.awvalid} = s_awvalid;
    assign {clint.wvalid,  uart.wvalid,  sram.wvalid}  = s_wvalid;
    assign {clint.bready,  uart.bready,  sram.bready}  = s_bready;

    // Payload fields go to every slave; only valid/ready decide who actually transfers.
    assign sram.araddr  = m.araddr;  assign uart.araddr  = m.araddr;  assign clint.araddr  = m.araddr;
    assign sram.awaddr  = m.awaddr;  assign uart.awaddr  = m.awaddr;  assign clint.awaddr  = m.awaddr;
    assign sram.wdata   = m.wdata;   assign uart.wdata   = m.wdata;   assign clint.wdata   = m.wdata;
    assign sram.wmask   = m.wmask;   assign uart.wmask   = m.wmask;   assign clint.wmask   = m.wmask;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= RD_IDLE;
            rd_sel   <= SEL_SRAM;
        end else begin
            rd_state <= rd_next;
            if (rd_state == RD_IDLE && m.arvalid && m.arready) rd_sel <= rd_dec;
        end
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (m.arvalid && m.arready) rd_next = (rd_dec == SEL_ERR) ? RD_ERR : RD_BUSY;
            RD_BUSY: if (m.rvalid && m.rready)   rd_next = RD_IDLE;
            RD_ERR:  if (m.rready)               rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    // Everything is forced quiet while reset is held so a stale state cannot leak a response.
    always_comb begin
        s_arvalid = '0;
        s_rready  = '0;
        m.arready = 1'b0;
        m.rvalid  = 1'b0;
        m.rdata   = '0;
        m.rresp   = '0;
        if (!reset) begin
            case (rd_state)
                RD_IDLE: begin
                    for (int i = 0; i < 3; i++) begin
                        if (rd_dec == 2'(i)) begin
                            s_arvalid[i] = m.arvalid;
                            m.arready    = s_arready[i];
                        end
                    end
                    if (rd_dec == SEL_ERR) m.arready = 1'b1;
                end
                RD_BUSY: begin
                    for (int i = 0; i < 3; i++) begin
                        if (rd_sel == 2'(i)) begin
                            m.rvalid    = s_rvalid[i];
                            m.rdata     = s_rdata[i];
                            m.rresp     = s_rresp[i];
                            s_rready[i] = m.rready;
                        end
                    end
                end
                RD_ERR: begin
                    m.rvalid = 1'b1;
                    m.rresp  = 2'b11;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state <= WR_IDLE;
            wr_sel   <= SEL_SRAM;
        end else begin
            wr_state <= wr_next;
            if (wr_state == WR_IDLE && m.awvalid && m.awready) wr_sel <= wr_dec;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE: begin
                if (m.awvalid && m.awready) begin
                    if (wr_dec != SEL_ERR) wr_next = WR_BUSY;
                    else                   wr_next = m.wvalid ? WR_ERR_B : WR_ERR_W;
                end
            end
            WR_BUSY:  if (m.bvalid && m.bready) wr_next = WR_IDLE;
            WR_ERR_W: if (m.wvalid)             wr_next = WR_ERR_B;
            WR_ERR_B: if (m.bready)             wr_next = WR_IDLE;
            default:  wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        s_awvalid = '0;
        s_wvalid  = '0;
        s_bready  = '0;
        m.awready = 1'b0;
        m.wready  = 1'b0;
        m.bvalid  = 1'b0;
        m.bresp   = '0;
        if (!reset) begin
            case (wr_state)
                WR_IDLE: begin
                    for (int i = 0; i < 3; i++) begin
                        if (wr_dec == 2'(i)) begin
                            s_awvalid[i] = m.awvalid;
                            s_wvalid[i]  = m.awvalid && m.wvalid;
                            m.awready    = s_awready[i];
                            m.wready     = m.awvalid && s_wready[i];
                        end
                    end
                    if (wr_dec == SEL_ERR) begin
                        m.awready = 1'b1;
                        m.wready  = m.awvalid;
                    end
                end
                WR_BUSY: begin
                    for (int i = 0; i < 3; i++) begin
                        if (wr_sel == 2'(i)) begin
                            s_wvalid[i] = m.wvalid;
                            m.wready    = s_wready[i];
                            m.bvalid    = s_bvalid[i];
                            m.bresp     = s_bresp[i];
                            s_bready[i] = m.bready;
                        end
                    end
                end
                WR_ERR_W: m.wready = 1'b1;
                WR_ERR_B: begin
                    m.bvalid = 1'b1;
                    m.bresp  = 2'b11;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_xbar.sv
// Directed bench for axi_lite_xbar: an address-range transaction model checks every cycle,
// while the directed sequences pin hand-computed values at key points.
module tb_axi_lite_xbar;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    axi_lite_if m_if ();
    axi_lite_if sram_if ();
    axi_lite_if uart_if ();
    axi_lite_if clint_if ();

    axi_lite_xbar dut (
        .clk   (clk),
        .reset (reset),
        .m     (m_if),
        .sram  (sram_if),
        .uart  (uart_if),
        .clint (clint_if)
    );

    int checks = 0;
    int failures = 0;

    wire [2:0] o_arvalid = {clint_if.arvalid, uart_if.arvalid, sram_if.arvalid};
    wire [2:0] o_rready  = {clint_if.rready,  uart_if.rready,  sram_if.rready};
    wire [2:0] o_awvalid = {clint_if.awvalid, uart_if.awvalid, sram_if.awvalid};
    wire [2:0] o_wvalid  = {clint_if.wvalid,  uart_if.wvalid,  sram_if.wvalid};
    wire [2:0] o_bready  = {clint_if.bready,  uart_if.bready,  sram_if.bready};
    wire [2:0] sl_arready = {clint_if.arready, uart_if.arready, sram_if.arready};
    wire [2:0] sl_rvalid  = {clint_if.rvalid,  uart_if.rvalid,  sram_if.rvalid};
    wire [2:0] sl_awready = {clint_if.awready, uart_if.awready, sram_if.awready};
    wire [2:0] sl_wready  = {clint_if.wready,  uart_if.wready,  sram_if.wready};
    wire [2:0] sl_bvalid  = {clint_if.bvalid,  uart_if.bvalid,  sram_if.bvalid};
    wire [31:0] sl_rdata [3];
    wire [1:0]  sl_rresp [3];
    wire [1:0]  sl_bresp [3];
    assign sl_rdata[0] = sram_if.rdata;  assign sl_rdata[1] = uart_if.rdata;  assign sl_rdata[2] = clint_if.rdata;
    assign sl_rresp[0] = sram_if.rresp;  assign sl_rresp[1] = uart_if.rresp;  assign sl_rresp[2] = clint_if.rresp;
    assign sl_bresp[0] = sram_if.bresp;  assign sl_bresp[1] = uart_if.bresp;  assign sl_bresp[2] = clint_if.bresp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Address map as plain inclusive ranges: 0 sram, 1 uart, 2 clint, 3 unmapped.
    function automatic int region(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'h87FF_FFFF) return 0;
        if (a >= 32'hA000_03F8 && a <= 32'hA000_03FF) return 1;
        if (a >= 32'hA000_0048 && a <= 32'hA000_004F) return 2;
        return 3;
    endfunction

    // Model: -1 nothing outstanding, 0..2 a slave owns the response, 3 the xbar answers with an error.
    int   rd_pend = -1;
    int   wr_pend = -1;
    logic wr_wdone = 1'b0;
    logic [2:0] ar_seen = '0;

    logic [2:0]  e_arv, e_rr, e_awv, e_wv, e_br;
    logic        e_arready, e_rvalid, e_awready, e_wready, e_bvalid;
    logic [31:0] e_rdata;
    logic [1:0]  e_rresp, e_bresp;
    int          t, u;

    always @(negedge clk) begin
        e_arv = '0; e_rr = '0; e_awv = '0; e_wv = '0; e_br = '0;
        e_arready = 0; e_rvalid = 0; e_awready = 0; e_wready = 0; e_bvalid = 0;
        e_rdata = '0; e_rresp = '0; e_bresp = '0;
        t = region(m_if.araddr);
        u = region(m_if.awaddr);
        ar_seen = ar_seen | o_arvalid;
        if (!reset) begin
            if (rd_pend < 0) begin
                if (t == 3) e_arready = 1'b1;
                else begin
                    e_arready = sl_arready[t];
                    e_arv[t]  = m_if.arvalid;
                end
            end else if (rd_pend < 3) begin
                e_rvalid = sl_rvalid[rd_pend];
                e_rdata  = sl_rdata[rd_pend];
                e_rresp  = sl_rresp[rd_pend];
                e_rr[rd_pend] = m_if.rready;
            end else begin
                e_rvalid = 1'b1;
                e_rresp  = 2'b11;
            end
            if (wr_pend < 0) begin
                if (u == 3) begin
                    e_awready = 1'b1;
                    e_wready  = m_if.awvalid;
                end else begin
                    e_awready = sl_awready[u];
                    e_wready  = m_if.awvalid && sl_wready[u];
                    e_awv[u]  = m_if.awvalid;
                    e_wv[u]   = m_if.awvalid && m_if.wvalid;
                end
            end else if (wr_pend < 3) begin
                e_wv[wr_pend] = m_if.wvalid;
                e_wready = sl_wready[wr_pend];
                e_bvalid = sl_bvalid[wr_pend];
                e_bresp  = sl_bresp[wr_pend];
                e_br[wr_pend] = m_if.bready;
            end else if (!wr_wdone) begin
                e_wready = 1'b1;
            end else begin
                e_bvalid = 1'b1;
                e_bresp  = 2'b11;
            end
        end
        chk("ctrl", 64'({m_if.arready, m_if.rvalid, m_if.awready, m_if.wready, m_if.bvalid,
                         o_arvalid, o_rready, o_awvalid, o_wvalid, o_bready}),
                    64'({e_arready, e_rvalid, e_awready, e_wready, e_bvalid,
                         e_arv, e_rr, e_awv, e_wv, e_br}));
        if (e_rvalid) chk("rdata", 64'({m_if.rresp, m_if.rdata}), 64'({e_rresp, e_rdata}));
        if (e_bvalid) chk("bresp", 64'(m_if.bresp), 64'(e_bresp));
        chk("fan_addr", {sram_if.araddr ^ uart_if.araddr ^ clint_if.araddr,
                         sram_if.awaddr ^ uart_if.awaddr ^ clint_if.awaddr},
                        {m_if.araddr, m_if.awaddr});
        chk("fan_wdata", {clint_if.wdata, 28'd0, uart_if.wmask}, {m_if.wdata, 28'd0, m_if.wmask});

        if (reset) begin
            rd_pend = -1; wr_pend = -1; wr_wdone = 1'b0;
        end else begin
            if (rd_pend < 0) begin
                if (m_if.arvalid && e_arready) rd_pend = t;
            end else if (e_rvalid && m_if.rready) rd_pend = -1;
            if (wr_pend < 0) begin
                if (m_if.awvalid && e_awready) begin
                    wr_pend  = u;
                    wr_wdone = (u == 3) && m_if.wvalid;
                end
            end else if (wr_pend < 3) begin
                if (e_bvalid && m_if.bready) wr_pend = -1;
            end else if (!wr_wdone) begin
                if (m_if.wvalid) wr_wdone = 1'b1;
            end else if (m_if.bready) wr_pend = -1;
        end
    end

    task automatic clear_all();
        m_if.araddr = '0; m_if.arvalid = 0; m_if.rready = 0;
        m_if.awaddr = '0; m_if.awvalid = 0; m_if.wdata = '0; m_if.wmask = '0;
        m_if.wvalid = 0; m_if.bready = 0;
        sram_if.arready = 0; sram_if.rvalid = 0; sram_if.rdata = '0; sram_if.rresp = '0;
        sram_if.awready = 0; sram_if.wready = 0; sram_if.bvalid = 0; sram_if.bresp = '0;
        uart_if.arready = 0; uart_if.rvalid = 0; uart_if.rdata = '0; uart_if.rresp = '0;
        uart_if.awready = 0; uart_if.wready = 0; uart_if.bvalid = 0; uart_if.bresp = '0;
        clint_if.arready = 0; clint_if.rvalid = 0; clint_if.rdata = '0; clint_if.rresp = '0;
        clint_if.awready = 0; clint_if.wready = 0; clint_if.bvalid = 0; clint_if.bresp = '0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] bnd_addr [9] = '{32'h87FF_FFFF, 32'h8800_0000, 32'hA000_03FF, 32'hA000_0400,
                                  32'hA000_03F7, 32'hA000_0048, 32'hA000_004F, 32'hA000_0050,
                                  32'h7FFF_FFFF};
    int          bnd_idx  [9] = '{0, 3, 1, 3, 3, 2, 2, 3, 3};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_all();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_valids", 64'({m_if.rvalid, m_if.bvalid, o_arvalid, o_awvalid, o_wvalid}), 64'd0);
        next(); next();
        reset = 1'b0;

        // SRAM read, response three cycles after the address
        m_if.araddr = 32'h8000_0010; m_if.arvalid = 1; sram_if.arready = 1; ar_seen = '0;
        @(negedge clk);
        chk("t1_ar", 64'({sram_if.arvalid, m_if.arready}), 64'b11);
        next(); m_if.arvalid = 0; sram_if.arready = 0; m_if.rready = 1;
        @(negedge clk);
        chk("t1_wait", 64'(m_if.rvalid), 64'd0);
        next(); next();
        sram_if.rvalid = 1; sram_if.rdata = 32'hDEAD_BEEF; sram_if.rresp = 2'b00;
        @(negedge clk);
        chk("t1_r", 64'({m_if.rvalid, m_if.rresp, m_if.rdata}), {29'd0, 1'b1, 2'b00, 32'hDEAD_BEEF});
        next(); sram_if.rvalid = 0; m_if.rready = 0;
        chk("t1_no_stray_ar", 64'(ar_seen[2:1]), 64'd0);

        // Unmapped read with the response held under back-pressure
        m_if.araddr = 32'h9000_0000; m_if.arvalid = 1;
        @(negedge clk);
        chk("t2_ar", 64'({m_if.arready, o_arvalid}), 64'b1000);
        next(); m_if.arvalid = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_hold", 64'({m_if.rvalid, m_if.rresp, m_if.rdata}), {29'd0, 1'b1, 2'b11, 32'd0});
            next();
        end
        m_if.rready = 1;
        @(negedge clk);
        chk("t2_take", 64'(m_if.rvalid), 64'd1);
        next(); m_if.rready = 0;
        @(negedge clk);
        chk("t2_done", 64'(m_if.rvalid), 64'd0);
        next();

        // UART write, AW and W together
        m_if.awaddr = 32'hA000_03F8; m_if.awvalid = 1; m_if.wvalid = 1;
        m_if.wdata = 32'h41; m_if.wmask = 4'b0001; uart_if.awready = 1; uart_if.wready = 1;
        @(negedge clk);
        chk("t3_uart_aw_w", 64'({uart_if.awvalid, uart_if.wvalid, m_if.awready, m_if.wready}), 64'b1111);
        chk("t3_uart_data", 64'({uart_if.wmask, uart_if.wdata}), {28'd0, 4'b0001, 32'h41});
        chk("t3_others", 64'({o_awvalid[2], o_awvalid[0], o_wvalid[2], o_wvalid[0]}), 64'd0);
        next(); m_if.awvalid = 0; m_if.wvalid = 0; uart_if.awready = 0; uart_if.wready = 0;
        m_if.bready = 1; uart_if.bvalid = 1; uart_if.bresp = 2'b00;
        @(negedge clk);
        chk("t3_b", 64'({m_if.bvalid, m_if.bresp, o_bready}), 64'b100010);
        next(); uart_if.bvalid = 0; m_if.bready = 0;

        // Unmapped write with W two cycles after AW
        m_if.awaddr = 32'h0000_0000; m_if.awvalid = 1; m_if.wdata = 32'hDEAD_DEAD; m_if.wmask = 4'hF;
        @(negedge clk);
        chk("t4_aw", 64'({m_if.awready, o_awvalid}), 64'b1000);
        next(); m_if.awvalid = 0;
        @(negedge clk);
        chk("t4_wait_w", 64'({m_if.bvalid, m_if.wready}), 64'b01);
        next(); m_if.wvalid = 1;
        @(negedge clk);
        chk("t4_w", 64'({m_if.wready, o_wvalid, m_if.bvalid}), 64'b10000);
        next(); m_if.wvalid = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t4_b_hold", 64'({m_if.bvalid, m_if.bresp}), 64'b111);
            next();
        end
        m_if.bready = 1;
        @(negedge clk);
        chk("t4_b_take", 64'(m_if.bvalid), 64'd1);
        next(); m_if.bready = 0;
        @(negedge clk);
        chk("t4_done", 64'(m_if.bvalid), 64'd0);
        next();

        // Concurrent CLINT read and SRAM write
        m_if.araddr = 32'hA000_0048; m_if.arvalid = 1; clint_if.arready = 1;
        m_if.awaddr = 32'h8000_0000; m_if.awvalid = 1; m_if.wvalid = 1;
        m_if.wdata = 32'h1234_5678; m_if.wmask = 4'hF; sram_if.awready = 1; sram_if.wready = 1;
        @(negedge clk);
        chk("t5_ready", 64'({m_if.arready, m_if.awready, m_if.wready}), 64'b111);
        chk("t5_route", 64'({o_arvalid, o_awvalid, o_wvalid}), 64'b100_001_001);
        next(); m_if.arvalid = 0; m_if.awvalid = 0; m_if.wvalid = 0;
        clint_if.arready = 0; sram_if.awready = 0; sram_if.wready = 0;
        m_if.rready = 1; m_if.bready = 1;
        clint_if.rvalid = 1; clint_if.rdata = 32'h0000_1234; sram_if.bvalid = 1;
        @(negedge clk);
        chk("t5_r", 64'({m_if.rvalid, m_if.rdata}), {31'd0, 1'b1, 32'h0000_1234});
        chk("t5_b", 64'({m_if.bvalid, m_if.bresp, o_rready, o_bready}), 64'b1_00_100_001);
        next(); clint_if.rvalid = 0; sram_if.bvalid = 0; m_if.rready = 0; m_if.bready = 0;

        // Reset while a SRAM read response is pending
        m_if.araddr = 32'h8000_0020; m_if.arvalid = 1; sram_if.arready = 1;
        next(); m_if.arvalid = 0; sram_if.arready = 0;
        sram_if.rvalid = 1; sram_if.rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("t6_busy", 64'(m_if.rvalid), 64'd1);
        next(); reset = 1;
        @(negedge clk);
        chk("t6_in_reset", 64'({m_if.rvalid, o_rready}), 64'd0);
        next(); reset = 0;
        @(negedge clk);
        chk("t6_late_ignored", 64'({m_if.rvalid, o_rready}), 64'd0);
        next(); sram_if.rvalid = 0;
        m_if.araddr = 32'h87FF_FFFC; m_if.arvalid = 1; sram_if.arready = 1;
        @(negedge clk);
        chk("t6_new_ar", 64'({o_arvalid, m_if.arready}), 64'b0011);
        next(); m_if.arvalid = 0; sram_if.arready = 0;
        sram_if.rvalid = 1; sram_if.rdata = 32'hCAFE_F00D; m_if.rready = 1;
        @(negedge clk);
        chk("t6_new_r", 64'({m_if.rvalid, m_if.rdata}), {31'd0, 1'b1, 32'hCAFE_F00D});
        next(); sram_if.rvalid = 0; m_if.rready = 0;

        // Decode boundaries on the read channel
        for (int k = 0; k < 9; k++) begin
            m_if.araddr = bnd_addr[k]; m_if.arvalid = 1; m_if.rready = 1;
            @(negedge clk);
            chk("bnd_route", 64'({m_if.arready, o_arvalid}),
                64'({bnd_idx[k] == 3, (bnd_idx[k] < 3) ? 3'(1 << bnd_idx[k]) : 3'b000}));
            next(); m_if.arvalid = 0;
            if (bnd_idx[k] == 3) begin
                @(negedge clk);
                chk("bnd_err", 64'({m_if.rvalid, m_if.rresp}), 64'b111);
                next();
            end
        end
        m_if.rready = 0;
        next(); next();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
